// File: rtl/rs422_link_sched.sv
// rs422_link_sched: queues HDLC commands, arbitrates them against self-check runs, and sequences engine starts with timeout and guard gap
module rs422_link_sched #(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int GAP_CYCLES     = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        cmd_push,
  input  logic [31:0] cmd_word,
  input  logic        selfcheck_req,
  input  logic        status_clear,
  input  logic        sc_finish,
  input  logic        hdlc_tx_finish,
  input  logic        hdlc_rx_finish,
  output logic        hdlc_start,
  output logic [31:0] hdlc_cmd,
  output logic        selfcheck_start,
  output logic        abort,
  output logic        busy,
  output logic [1:0]  mode,
  output logic [4:0]  fifo_level,
  output logic        err_overflow,
  output logic        err_timeout,
  output logic [15:0] done_cnt
);
  localparam int          AW       = $clog2(DEPTH);
  localparam logic [23:0] TMO_LAST = 24'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] GAP_LAST = 32'(GAP_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, SC_RUN, HD_RUN, GAP} state_t;
  state_t        r_state;
  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic          r_sc_pend, r_tx_seen, r_rx_seen;
  logic [23:0]   r_tmo_cnt;
  logic [31:0]   r_gap_cnt;
  logic          w_empty, w_full, w_sc_want, w_sc_go, w_pop, w_accept, w_drop;
  logic          w_tx, w_rx, w_done, w_tmo, w_run;
  assign w_empty   = fifo_level == 5'd0;
  assign w_full    = fifo_level == 5'(DEPTH);
  assign w_sc_want = r_sc_pend | selfcheck_req;
  assign w_sc_go   = (r_state == IDLE) & w_sc_want;
  // A push into an empty FIFO while IDLE is popped in the same cycle so the start comes one cycle later
  assign w_pop     = (r_state == IDLE) & ~w_sc_want & (~w_empty | cmd_push);
  assign w_accept  = cmd_push & (~w_full | w_pop);
  assign w_drop    = cmd_push & ~w_accept;
  assign w_tx      = r_tx_seen | hdlc_tx_finish;
  assign w_rx      = r_rx_seen | hdlc_rx_finish;
  assign w_run     = (r_state == SC_RUN) | (r_state == HD_RUN);
  assign w_done    = ((r_state == SC_RUN) & sc_finish) | ((r_state == HD_RUN) & w_tx & w_rx);
  assign w_tmo     = w_run & ~w_done & (r_tmo_cnt == TMO_LAST);
  // FIFO storage; contents become unreachable once the pointers reset
  always_ff @(posedge clk)
    if (w_accept) r_mem[r_wr_ptr] <= cmd_word;
  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      fifo_level <= 5'd0;
    end else begin
      if (w_accept) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      fifo_level <= fifo_level + 5'(w_accept) - 5'(w_pop);
    end
  // Scheduler FSM with registered start/abort pulses, status and counters
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      r_state         <= IDLE;
      r_sc_pend       <= 1'b0;
      r_tx_seen       <= 1'b0;
      r_rx_seen       <= 1'b0;
      r_tmo_cnt       <= 24'd0;
      r_gap_cnt       <= 32'd0;
      hdlc_start      <= 1'b0;
      hdlc_cmd        <= 32'd0;
      selfcheck_start <= 1'b0;
      abort           <= 1'b0;
      busy            <= 1'b0;
      mode            <= 2'b00;
      err_overflow    <= 1'b0;
      err_timeout     <= 1'b0;
      done_cnt        <= 16'd0;
    end else begin
      hdlc_start      <= 1'b0;
      selfcheck_start <= 1'b0;
      abort           <= 1'b0;
      r_sc_pend       <= w_sc_want & ~w_sc_go;
      err_overflow    <= w_drop | (err_overflow & ~status_clear);
      err_timeout     <= w_tmo | (err_timeout & ~status_clear);
      r_tmo_cnt       <= r_tmo_cnt + 24'd1;
      case (r_state)
        IDLE:
          if (w_sc_go) begin
            r_state         <= SC_RUN;
            selfcheck_start <= 1'b1;
            busy            <= 1'b1;
            mode            <= 2'b01;
            r_tmo_cnt       <= 24'd0;
          end else if (w_pop) begin
            r_state    <= HD_RUN;
            hdlc_start <= 1'b1;
            hdlc_cmd   <= w_empty ? cmd_word : r_mem[r_rd_ptr];
            busy       <= 1'b1;
            mode       <= 2'b10;
            r_tmo_cnt  <= 24'd0;
          end
        SC_RUN, HD_RUN:
          if (w_done | w_tmo) begin
            r_state   <= GAP;
            mode      <= 2'b00;
            r_gap_cnt <= 32'd0;
            r_tx_seen <= 1'b0;
            r_rx_seen <= 1'b0;
            abort     <= w_tmo;
            done_cnt  <= done_cnt + 16'(w_done);
          end else begin
            r_tx_seen <= w_tx & (r_state == HD_RUN);
            r_rx_seen <= w_rx & (r_state == HD_RUN);
          end
        GAP:
          if (r_gap_cnt == GAP_LAST) begin
            r_state <= IDLE;
            busy    <= 1'b0;
          end else r_gap_cnt <= r_gap_cnt + 32'd1;
      endcase
    end
endmodule

// File: tb/tb_rs422_link_sched.sv
// tb_rs422_link_sched: directed checks of queueing, priority, overflow, timeout and reset behaviour
module tb_rs422_link_sched;
  localparam int GAP = 8;
  logic        clk = 1'b0, rstn = 1'b0;
  logic        cmd_push = 1'b0, selfcheck_req = 1'b0, status_clear = 1'b0;
  logic        sc_finish = 1'b0, hdlc_tx_finish = 1'b0, hdlc_rx_finish = 1'b0;
  logic [31:0] cmd_word = 32'd0;
  logic        hdlc_start, selfcheck_start, abort, busy, err_overflow, err_timeout;
  logic [31:0] hdlc_cmd;
  logic [1:0]  mode;
  logic [4:0]  fifo_level;
  logic [15:0] done_cnt;
  int          n_checks = 0, n_fail = 0, n, starts;
  rs422_link_sched #(.DEPTH(4), .TIMEOUT_CYCLES(100), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rstn(rstn), .cmd_push(cmd_push), .cmd_word(cmd_word),
    .selfcheck_req(selfcheck_req), .status_clear(status_clear), .sc_finish(sc_finish),
    .hdlc_tx_finish(hdlc_tx_finish), .hdlc_rx_finish(hdlc_rx_finish),
    .hdlc_start(hdlc_start), .hdlc_cmd(hdlc_cmd), .selfcheck_start(selfcheck_start),
    .abort(abort), .busy(busy), .mode(mode), .fifo_level(fifo_level),
    .err_overflow(err_overflow), .err_timeout(err_timeout), .done_cnt(done_cnt)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic wait_hdlc(output int cyc);
    cyc = 0;
    while (hdlc_start !== 1'b1 && cyc < 300) begin
      tick();
      cyc++;
    end
  endtask
  task automatic wait_abort(output int cyc);
    cyc = 0;
    while (abort !== 1'b1 && cyc < 300) begin
      tick();
      cyc++;
    end
  endtask
  task automatic finish_both();
    hdlc_tx_finish = 1'b1;
    hdlc_rx_finish = 1'b1;
    tick();
    hdlc_tx_finish = 1'b0;
    hdlc_rx_finish = 1'b0;
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_mode", mode, 0);
    check("rst_cmd", hdlc_cmd, 0);
    check("rst_level", fifo_level, 0);
    check("rst_flags", {err_overflow, err_timeout, abort, hdlc_start, selfcheck_start}, 0);
    check("rst_done", done_cnt, 0);
    rstn = 1'b1;
    tick();
    // single command
    cmd_push = 1'b1;
    cmd_word = 32'hA5A5_0001;
    tick();
    cmd_push = 1'b0;
    check("single_start", hdlc_start, 1);
    check("single_cmd", hdlc_cmd, 32'hA5A5_0001);
    check("single_busy_mode", {busy, mode}, 3'b110);
    check("single_level", fifo_level, 0);
    tick();
    check("single_pulse", hdlc_start, 0);
    hdlc_tx_finish = 1'b1;
    tick();
    hdlc_tx_finish = 1'b0;
    repeat (2) tick();
    check("tx_only_mode", mode, 2'b10);
    hdlc_rx_finish = 1'b1;
    tick();
    hdlc_rx_finish = 1'b0;
    check("single_done", done_cnt, 1);
    check("gap_busy_mode", {busy, mode}, 3'b100);
    repeat (GAP - 1) tick();
    check("gap_end_busy", busy, 1);
    tick();
    check("idle_busy", busy, 0);
    // self-check priority over queued commands
    cmd_push = 1'b1;
    cmd_word = 32'h0000_0011;
    selfcheck_req = 1'b1;
    tick();
    selfcheck_req = 1'b0;
    cmd_word = 32'h0000_0022;
    check("prio_sc_start", selfcheck_start, 1);
    check("prio_no_hdlc", hdlc_start, 0);
    check("prio_mode", mode, 2'b01);
    tick();
    cmd_push = 1'b0;
    check("prio_level", fifo_level, 2);
    sc_finish = 1'b1;
    tick();
    sc_finish = 1'b0;
    check("sc_done", done_cnt, 2);
    check("sc_gap_mode", mode, 0);
    wait_hdlc(n);
    check("prio_lat1", n, GAP + 1);
    check("prio_cmd1", hdlc_cmd, 32'h11);
    check("prio_level1", fifo_level, 1);
    finish_both();
    wait_hdlc(n);
    check("prio_lat2", n, GAP + 1);
    check("prio_cmd2", hdlc_cmd, 32'h22);
    finish_both();
    check("prio_done", done_cnt, 4);
    // overflow while busy
    for (int i = 0; i < 5; i++) begin
      cmd_push = 1'b1;
      cmd_word = 32'hB0 + 32'(i);
      tick();
    end
    cmd_push = 1'b0;
    check("ovf_level", fifo_level, 4);
    check("ovf_flag", err_overflow, 1);
    status_clear = 1'b1;
    tick();
    status_clear = 1'b0;
    check("ovf_clear", err_overflow, 0);
    wait_hdlc(n);
    check("ovf_lat", n, 3);
    check("ovf_cmd", hdlc_cmd, 32'hB0);
    // timeout with only tx finish
    hdlc_tx_finish = 1'b1;
    tick();
    hdlc_tx_finish = 1'b0;
    wait_abort(n);
    check("tmo_lat", n, 99);
    check("tmo_flag", err_timeout, 1);
    check("tmo_done", done_cnt, 4);
    check("tmo_mode", {busy, mode}, 3'b100);
    tick();
    check("tmo_pulse", abort, 0);
    status_clear = 1'b1;
    tick();
    status_clear = 1'b0;
    check("tmo_clear", err_timeout, 0);
    wait_hdlc(n);
    check("tmo_next_lat", n, 7);
    check("tmo_next_cmd", hdlc_cmd, 32'hB1);
    // completion exactly at the timeout limit
    repeat (99) tick();
    finish_both();
    check("edge_abort", abort, 0);
    check("edge_tmo", err_timeout, 0);
    check("edge_done", done_cnt, 5);
    wait_hdlc(n);
    check("edge_next_lat", n, GAP + 1);
    check("edge_next_cmd", hdlc_cmd, 32'hB2);
    check("edge_level", fifo_level, 1);
    // push and pop together while full
    cmd_push = 1'b1;
    cmd_word = 32'hC0;
    hdlc_tx_finish = 1'b1;
    hdlc_rx_finish = 1'b1;
    tick();
    hdlc_tx_finish = 1'b0;
    hdlc_rx_finish = 1'b0;
    cmd_word = 32'hC1;
    tick();
    cmd_word = 32'hC2;
    tick();
    cmd_push = 1'b0;
    check("full_level", fifo_level, 4);
    repeat (6) tick();
    check("full_idle", busy, 0);
    cmd_push = 1'b1;
    cmd_word = 32'hC3;
    tick();
    cmd_push = 1'b0;
    check("pp_start", hdlc_start, 1);
    check("pp_cmd", hdlc_cmd, 32'hB3);
    check("pp_level", fifo_level, 4);
    check("pp_no_ovf", err_overflow, 0);
    finish_both();
    check("pp_done", done_cnt, 7);
    wait_hdlc(n);
    check("pp_next_lat", n, GAP + 1);
    check("pp_next_cmd", hdlc_cmd, 32'hC0);
    check("pp_next_level", fifo_level, 3);
    // asynchronous reset mid-transaction
    rstn = 1'b0;
    #1;
    check("mid_rst_start", hdlc_start, 0);
    check("mid_rst_cmd", hdlc_cmd, 0);
    check("mid_rst_busy_mode", {busy, mode}, 0);
    check("mid_rst_level", fifo_level, 0);
    check("mid_rst_done", done_cnt, 0);
    repeat (2) tick();
    rstn = 1'b1;
    starts = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      starts += int'(hdlc_start) + int'(selfcheck_start);
    end
    check("post_rst_starts", starts, 0);
    check("post_rst_level", fifo_level, 0);
    check("post_rst_busy", busy, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/rs422_link_sched.md
# rs422_link_sched

Transaction scheduler for the RS422 link datapath. It sits between the AXI-Lite register slice and the two link engines: the HDLC command transmit/receive pair and the loopback self-check pair. It queues HDLC command words, arbitrates them against self-check requests, and issues one-cycle start pulses to the engines. It waits for completion or a timeout, then holds a guard gap before the next transaction, and exports busy, mode, queue and error status for readback.

## Interface
Parameters:
- DEPTH, 4: command FIFO depth (power of two, 2..16)
- TIMEOUT_CYCLES, 2000000: cycles allowed per transaction before abort (≥2, ≤2^24-1)
- GAP_CYCLES, 8: idle guard cycles between transactions (≥1)

Ports:
- clk  in  1  system clock (the AXI/link clock)
- rstn  in  1  reset; one clock, reset is asynchronous and active-low
- cmd_push  in  1  enqueue cmd_word this cycle
- cmd_word  in  32  HDLC command word
- selfcheck_req  in  1  request a self-check run (pulse or level; sampled per cycle)
- status_clear  in  1  clear sticky error flags
- sc_finish  in  1  self-check receiver finished
- hdlc_tx_finish  in  1  HDLC transmitter finished
- hdlc_rx_finish  in  1  HDLC receiver finished
- hdlc_start  out  1  one-cycle start to HDLC engines
- hdlc_cmd  out  32  command word for current HDLC transaction; held until next pop
- selfcheck_start  out  1  one-cycle start to self-check engines
- abort  out  1  one-cycle pulse on timeout; engines drop their enables
- busy  out  1  high in any state other than IDLE
- mode  out  2  00 idle/gap, 01 self-check running, 10 HDLC running
- fifo_level  out  5  queued words, 0..DEPTH
- err_overflow  out  1  sticky: push dropped because the FIFO was full
- err_timeout  out  1  sticky: a transaction timed out
- done_cnt  out  16  completed transactions; wraps at 0xFFFF→0

## Operation
- FIFO: DEPTH entries with wrapping read/write pointers. A push while full drops the word and sets err_overflow. When a push and a pop coincide while full, the push is accepted (level unchanged).
- sc_pend flag: set by selfcheck_req. Multiple requests while it is pending merge into one. It is cleared when the self-check starts.
- States: IDLE, SC_RUN, HD_RUN, GAP.
- IDLE, sc_pend=1: go to SC_RUN and pulse selfcheck_start. Self-check has priority over queued commands.
- IDLE, sc_pend=0 and FIFO not empty: pop the FIFO head into hdlc_cmd, pulse hdlc_start, go to HD_RUN.
- SC_RUN: on sc_finish, go to GAP and increment done_cnt.
- HD_RUN: tx_seen and rx_seen latch hdlc_tx_finish and hdlc_rx_finish independently, in any order or in the same cycle. When both are seen, go to GAP, increment done_cnt, and clear both latches.
- Timeout: a 24-bit counter loads 0 on entry to a RUN state and increments each cycle. If the counter reaches TIMEOUT_CYCLES-1 without completion, pulse abort, set err_timeout, and go to GAP. done_cnt is unchanged.
- Completion and timeout in the same cycle: completion wins (no abort).
- GAP: counts GAP_CYCLES cycles, then goes to IDLE.
- Finish inputs outside their own RUN state are ignored.
- status_clear clears both sticky flags. If an error event occurs in the same cycle, the set wins.
- A request arriving during a RUN or GAP state waits. No preemption.

## Timing
- Reset values: state IDLE; hdlc_start=0, selfcheck_start=0, abort=0, busy=0, mode=00, hdlc_cmd=0, fifo_level=0, err_overflow=0, err_timeout=0, done_cnt=0, sc_pend=0, latches 0.
- Reset mid-transaction: all of the above takes effect immediately and the FIFO contents are discarded.
- All outputs are registered.
- Start latency: a cmd_push or selfcheck_req in cycle N (with the scheduler in IDLE) produces the start pulse in cycle N+1. busy and mode are updated in cycle N+1 as well.
- hdlc_cmd is valid in the same cycle as hdlc_start and stays stable through HD_RUN and GAP.
- Completion: with the finish condition met in cycle M, busy stays high, mode=00 from M+1, and IDLE is reached at M+1+GAP_CYCLES. The next start comes one cycle later.
- abort is high in exactly one cycle: the cycle after the counter hits TIMEOUT_CYCLES-1.
- fifo_level reflects a push or pop on the cycle after it occurs.

## Test plan
- Single command: push 0xA5A5_0001 in IDLE → hdlc_start one cycle later with hdlc_cmd=0xA5A5_0001. Then tx_finish, and rx_finish 3 cycles later → done_cnt=1, IDLE after GAP_CYCLES+1 cycles.
- Priority: push 2 words and assert selfcheck_req in the same cycle → selfcheck_start first, then the two HDLC starts in FIFO order, each separated by ≥GAP_CYCLES+1 cycles.
- Overflow: push 5 words with DEPTH=4 while busy → fifo_level=4, err_overflow=1, the 5th word is never issued. status_clear → err_overflow=0.
- Timeout: TIMEOUT_CYCLES=100, start HDLC, send only tx_finish → abort pulse at cycle 100 after start, err_timeout=1, done_cnt unchanged, next queued command still issued.
- Simultaneous events: tx_finish and rx_finish in the same cycle exactly at the timeout limit → completion counted, no abort. Push and pop in the same cycle when full → word accepted, level stays 4.
- Reset mid-run: deassert rstn during HD_RUN with 3 words queued → every output returns to its reset value, and no start is issued after rstn is released.
